// File: rtl/mem_arbiter_pkg.sv
// Shared load/store op encodings and response-tag constants for the
// data-memory arbiter and its load-alignment helper.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W        = 11;
    localparam int DEF_DATA_W        = 32;
    localparam int DEF_IF_STARVE_MAX = 4;

    // Bit 2 set = store; bits [1:0] = size (0 byte, 1 half, 2 word).
    typedef enum logic [2:0] {
        OP_LB = 3'b000,
        OP_LH = 3'b001,
        OP_LW = 3'b010,
        OP_SB = 3'b100,
        OP_SH = 3'b101,
        OP_SW = 3'b110
    } mem_op_e;

    localparam logic MEM_SRC_IF = 1'b0;
    localparam logic MEM_SRC_LS = 1'b1;

    function automatic logic op_is_store(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/mem_arbiter_load_align.sv
// Combinational load extraction: picks the byte/half lane from a raw memory
// word and sign-extends it; word loads pass through unchanged.
module mem_arbiter_load_align
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_off,
    output logic [31:0] o_data
);

    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = i_data[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_lane[i_off];
    // Half loads ignore off[0]; a misaligned half simply reads its aligned pair.
    assign w_half = i_off[1] ? i_data[31:16] : i_data[15:0];

    always_comb begin
        o_data = i_data;
        case (i_op)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared data memory between instruction fetch and load/store,
// with an IF starvation limit and a one-entry tagged read-response register.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int IF_STARVE_MAX = DEF_IF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic [2:0]        ls_op,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_stall,
    output logic [2:0]        mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STARVE_W = $clog2(IF_STARVE_MAX + 1);

    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_resp_vld;
    logic                r_resp_src;
    logic [2:0]          r_resp_op;
    logic [1:0]          r_resp_off;

    logic w_if_starved;
    logic w_if_gnt;
    logic w_ls_gnt;
    logic w_ls_store;

    assign w_if_starved = (r_starve_cnt == STARVE_W'(IF_STARVE_MAX));
    assign w_ls_store   = op_is_store(ls_op);
    assign w_ls_gnt     = ~rst & ls_req & ~(if_req & w_if_starved);
    assign w_if_gnt     = ~rst & if_req & ~w_ls_gnt;

    assign if_gnt = w_if_gnt;
    assign ls_gnt = w_ls_gnt;

    // Loads always go out as word loads; sub-word extraction happens on the
    // response side so back-to-back pipelined accesses never see a stale op.
    always_comb begin
        mem_stall = ~(w_if_gnt | w_ls_gnt);
        mem_op    = OP_LW;
        mem_addr  = ls_addr;
        mem_wdata = ls_wdata;
        if (w_if_gnt) begin
            mem_addr = if_addr;
        end else if (w_ls_gnt && w_ls_store) begin
            mem_op = ls_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!if_req || w_if_gnt) begin
            r_starve_cnt <= '0;
        end else if (!w_if_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_vld <= 1'b0;
        end else begin
            r_resp_vld <= w_if_gnt | (w_ls_gnt & ~w_ls_store);
        end
    end

    always_ff @(posedge clk) begin
        if (w_if_gnt || w_ls_gnt) begin
            r_resp_src <= w_ls_gnt ? MEM_SRC_LS : MEM_SRC_IF;
            r_resp_op  <= ls_op;
            r_resp_off <= w_if_gnt ? if_addr[1:0] : ls_addr[1:0];
        end
    end

    // Masking with rst drops a response whose cycle coincides with reset.
    assign if_rvalid = r_resp_vld & (r_resp_src == MEM_SRC_IF) & ~rst;
    assign ls_rvalid = r_resp_vld & (r_resp_src == MEM_SRC_LS) & ~rst;
    assign if_rdata  = mem_rdata;

    mem_arbiter_load_align u_load_align (
        .i_data (mem_rdata),
        .i_op   (r_resp_op),
        .i_off  (r_resp_off),
        .o_data (ls_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-level memory model plus a
// rule-based arbitration/response model, directed scenarios and random traffic.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic [2:0]    ls_op;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_stall;
    logic [2:0]    mem_op;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .IF_STARVE_MAX (SMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_op     (ls_op),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_stall (mem_stall),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Banked word memory with 1-cycle read latency, returning raw words.
    logic [31:0] mem_words [512];
    logic [8:0]  mem_widx;
    logic        mem_clr;
    assign mem_widx = {mem_addr[10], mem_addr[9:2]};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem_words[i] <= '0;
        end else if (!mem_stall) begin
            case (mem_op)
                OP_SB:   mem_words[mem_widx][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
                OP_SH:   mem_words[mem_widx][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                OP_SW:   mem_words[mem_widx] <= mem_wdata;
                default: mem_rdata <= mem_words[mem_widx];
            endcase
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory image, starvation count, pending response.
    logic [7:0]  m_bytes [2048];
    int          m_starve = 0;
    bit          m_pend_vld = 1'b0;
    bit          m_pend_ls  = 1'b0;
    logic [31:0] m_pend_data = '0;
    bit          m_en = 1'b0;

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [10:0] a);
        logic [10:0] a2;
        logic [10:0] a4;
        logic [7:0]  b;
        logic [15:0] h;
        a2 = {a[10:1], 1'b0};
        a4 = {a[10:2], 2'b00};
        if (op == OP_LB) begin
            b = m_bytes[a];
            return {{24{b[7]}}, b};
        end else if (op == OP_LH) begin
            h = {m_bytes[a2 + 11'd1], m_bytes[a2]};
            return {{16{h[15]}}, h};
        end
        return {m_bytes[a4 + 11'd3], m_bytes[a4 + 11'd2], m_bytes[a4 + 11'd1], m_bytes[a4]};
    endfunction

    task automatic model_store(input logic [2:0] op, input logic [10:0] a, input logic [31:0] d);
        if (op == OP_SB) begin
            m_bytes[a] = d[7:0];
        end else if (op == OP_SH) begin
            m_bytes[{a[10:1], 1'b0}] = d[7:0];
            m_bytes[{a[10:1], 1'b1}] = d[15:8];
        end else begin
            for (int k = 0; k < 4; k++) m_bytes[{a[10:2], 2'(k)}] = d[8*k +: 8];
        end
    endtask

    initial begin
        bit exp_if_g;
        bit exp_ls_g;
        bit ls_store;
        for (int i = 0; i < 2048; i++) m_bytes[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (m_en) begin
                ls_store = (ls_op == OP_SB) || (ls_op == OP_SH) || (ls_op == OP_SW);
                if (rst) begin
                    exp_if_g = 1'b0;
                    exp_ls_g = 1'b0;
                end else begin
                    exp_if_g = if_req && (!ls_req || m_starve >= SMAX);
                    exp_ls_g = ls_req && !exp_if_g;
                end
                check("if_gnt", 32'(if_gnt), 32'(exp_if_g));
                check("ls_gnt", 32'(ls_gnt), 32'(exp_ls_g));
                check("mem_stall", 32'(mem_stall), 32'(!(exp_if_g || exp_ls_g)));
                if (exp_if_g) begin
                    check("if_mem_op", 32'(mem_op), 32'(OP_LW));
                    check("if_mem_addr", 32'(mem_addr), 32'(if_addr));
                end
                if (exp_ls_g) begin
                    check("ls_mem_addr", 32'(mem_addr), 32'(ls_addr));
                    check("ls_mem_op", 32'(mem_op), ls_store ? 32'(ls_op) : 32'(OP_LW));
                    if (ls_store) check("ls_mem_wdata", mem_wdata, ls_wdata);
                end
                check("if_rvalid", 32'(if_rvalid), 32'(m_pend_vld && !m_pend_ls && !rst));
                check("ls_rvalid", 32'(ls_rvalid), 32'(m_pend_vld && m_pend_ls && !rst));
                if (m_pend_vld && !rst) begin
                    if (m_pend_ls) check("ls_rdata", ls_rdata, m_pend_data);
                    else           check("if_rdata", if_rdata, m_pend_data);
                end

                m_pend_vld = 1'b0;
                if (rst) begin
                    m_starve = 0;
                end else if (exp_if_g) begin
                    m_starve    = 0;
                    m_pend_vld  = 1'b1;
                    m_pend_ls   = 1'b0;
                    m_pend_data = model_load(OP_LW, if_addr);
                    $display("[TB] t=%0t IF  read  addr=%h", $time, if_addr);
                end else begin
                    m_starve = if_req ? ((m_starve < SMAX) ? m_starve + 1 : m_starve) : 0;
                    if (exp_ls_g) begin
                        if (ls_store) begin
                            model_store(ls_op, ls_addr, ls_wdata);
                            $display("[TB] t=%0t LS  store op=%0d addr=%h data=%h", $time, ls_op, ls_addr, ls_wdata);
                        end else begin
                            m_pend_vld  = 1'b1;
                            m_pend_ls   = 1'b1;
                            m_pend_data = model_load(ls_op, ls_addr);
                            $display("[TB] t=%0t LS  load  op=%0d addr=%h", $time, ls_op, ls_addr);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        if_req = 1'b0;
        ls_req = 1'b0;
    endtask

    task automatic drive_ls(input logic [2:0] op, input logic [10:0] a, input logic [31:0] d);
        ls_req   = 1'b1;
        ls_op    = op;
        ls_addr  = a;
        ls_wdata = d;
    endtask

    task automatic drive_if(input logic [10:0] a);
        if_req  = 1'b1;
        if_addr = a;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tmp;
        logic [2:0]  ops [6];
        ops = '{OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW};

        rst = 1'b1; mem_clr = 1'b1;
        if_req = 1'b1; if_addr = '0;
        ls_req = 1'b1; ls_op = OP_LW; ls_addr = '0; ls_wdata = '0;

        step();
        mem_clr = 1'b0;
        m_en    = 1'b1;
        @(negedge clk);
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_ls_gnt", 32'(ls_gnt), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd1);
        step();
        rst = 1'b0;
        drive_idle();

        // Preload through the arbiter's store path.
        step(); drive_ls(OP_SW, 11'h004, 32'hDEADBEEF);
        step(); drive_ls(OP_SW, 11'h400, 32'h11223344);
        step(); drive_ls(OP_SW, 11'h000, 32'h80001234);
        step(); drive_idle();

        // IF word read.
        step(); drive_if(11'h004);
        @(negedge clk);
        check("t1_if_gnt", 32'(if_gnt), 32'd1);
        step(); drive_idle();
        @(negedge clk);
        check("t1_if_rvalid", 32'(if_rvalid), 32'd1);
        check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        check("t1_ls_rvalid", 32'(ls_rvalid), 32'd0);

        // Store byte then load it back, then the whole word.
        step(); drive_ls(OP_SB, 11'h401, 32'h000000A5);
        step(); drive_ls(OP_LB, 11'h401, 32'h0);
        step(); drive_ls(OP_LW, 11'h400, 32'h0);
        @(negedge clk);
        check("t2_ls_rvalid", 32'(ls_rvalid), 32'd1);
        check("t2_lb_rdata", ls_rdata, 32'hFFFFFFA5);
        step(); drive_idle();
        @(negedge clk);
        check("t2_lw_rdata", ls_rdata, 32'h1122A544);
        check("t2_bank1_word", mem_words[256], 32'h1122A544);

        // Both requesting continuously: LS x4 then IF.
        step(); drive_if(11'h008); drive_ls(OP_LW, 11'h404, 32'h0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("t3_grant_seq", 32'(if_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
            step();
        end
        drive_idle();

        // Half load followed immediately by an IF read.
        step(); drive_ls(OP_LH, 11'h002, 32'h0);
        step(); ls_req = 1'b0; drive_if(11'h004);
        @(negedge clk);
        check("t4_ls_rvalid", 32'(ls_rvalid), 32'd1);
        check("t4_lh_rdata", ls_rdata, 32'hFFFF8000);
        check("t4_if_gnt", 32'(if_gnt), 32'd1);
        step(); drive_idle();
        @(negedge clk);
        check("t4_if_rdata", if_rdata, 32'hDEADBEEF);
        check("t4_ls_rvalid_lo", 32'(ls_rvalid), 32'd0);

        // Reset right behind an accepted load.
        step(); drive_ls(OP_LW, 11'h400, 32'h0);
        step(); rst = 1'b1; if_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5_ls_rvalid", 32'(ls_rvalid), 32'd0);
            check("t5_stall", 32'(mem_stall), 32'd1);
            check("t5_gnts", {30'd0, if_gnt, ls_gnt}, 32'd0);
            step();
        end
        rst = 1'b0; ls_req = 1'b0; drive_if(11'h004);
        step(); drive_idle();
        @(negedge clk);
        check("t5_if_rvalid", 32'(if_rvalid), 32'd1);
        check("t5_if_rdata", if_rdata, 32'hDEADBEEF);

        // Idle for 10 cycles.
        step(); drive_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_stall", 32'(mem_stall), 32'd1);
            check("t6_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
            step();
        end
        check("t6_word0", mem_words[0], 32'h80001234);
        check("t6_word1", mem_words[1], 32'hDEADBEEF);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            tmp      = $urandom;
            rst      = ($urandom_range(0, 99) == 0);
            if_req   = (tmp[1:0] != 2'b00);
            if_addr  = {tmp[2], 4'b0000, tmp[6:3], 2'b00};
            ls_req   = (tmp[8:7] != 2'b00);
            ls_addr  = {tmp[9], 4'b0000, tmp[13:10], tmp[15:14]};
            ls_op    = ops[$urandom_range(0, 5)];
            ls_wdata = $urandom;
            step();
        end
        rst = 1'b0;
        drive_idle();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
